// File: rtl/stopwatch_core.sv
// stopwatch_core: four-digit BCD stopwatch (SS.hh) with start/stop and
// lap/reset buttons.
//
// Ports:
//   clk     - sole clock, rising edge
//   rst_n   - asynchronous active-low reset
//   btn_ss  - raw start/stop button, active high, asynchronous
//   btn_lr  - raw lap/reset button, active high, asynchronous
//   digit1  - BCD tens of seconds (registered)
//   digit2  - BCD units of seconds (registered)
//   digit3  - BCD tenths (registered)
//   digit4  - BCD hundredths (registered)
//   ptflag  - decimal-point enable, high while RUN or LAP
//   ovf     - one-cycle pulse when the live count wraps 99.99 -> 00.00
//
// Button events (ss_ev, lr_ev) are single-cycle strobes. A strobe is valid
// for exactly the one cycle it is high and is consumed by the FSM on that
// same cycle; there is no ready/back-pressure path.
//
// Assumes TICK_DIV >= 2 and DEBOUNCE >= 1.
module stopwatch_core #(
  parameter int TICK_DIV = 500000,
  parameter int DEBOUNCE = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic       ptflag,
  output logic       ovf
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] DB_ONE   = DW'(1);

  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

  state_t state, next_state;

  // Button path; index 0 = start/stop, index 1 = lap/reset.
  logic [1:0]         raw;
  logic [1:0]         sync1, sync2;
  logic [1:0]         acc, acc_d;
  logic [1:0][DW-1:0] db_cnt;
  logic [1:0]         ev;
  logic               ss_ev, lr_ev;

  logic [PW-1:0]      pre;
  logic               counting, tick, hold_load, clear_cnt;

  // Digit 0 is hundredths, digit 3 is tens of seconds.
  logic [3:0][3:0]    live, live_inc, hold, disp;
  logic               wrap;

  assign raw = {btn_lr, btn_ss};

  // Synchronizers and debouncers. A debounce counter only runs while the
  // synchronized level disagrees with the accepted level, so any agreeing
  // cycle restarts the qualification window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      acc    <= '0;
      acc_d  <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      acc_d <= acc;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == acc[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          acc[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // Only press (0->1) edges of the accepted level produce events.
  assign ev    = acc & ~acc_d;
  assign ss_ev = ev[0];
  assign lr_ev = ev[1];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next state; start/stop always wins over a simultaneous lap/reset.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (ss_ev) next_state = RUN;
      RUN: begin
        if (ss_ev)      next_state = STOP;
        else if (lr_ev) next_state = LAP;
      end
      LAP: begin
        if (ss_ev)      next_state = STOP;
        else if (lr_ev) next_state = RUN;
      end
      STOP: begin
        if (ss_ev)      next_state = RUN;
        else if (lr_ev) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    counting  = (state == RUN) || (state == LAP);
    ptflag    = counting;
    hold_load = (state == RUN)  && lr_ev && !ss_ev;
    clear_cnt = (state == STOP) && lr_ev && !ss_ev;
  end

  assign tick = counting && (pre == PRE_LAST);

  // Prescaler: counts in RUN/LAP, holds in STOP, zero in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (clear_cnt || (state == IDLE)) begin
      pre <= '0;
    end else if (counting) begin
      pre <= tick ? '0 : pre + PRE_ONE;
    end
  end

  // BCD ripple increment; wrap is set when every digit was 9.
  always_comb begin
    live_inc = live;
    wrap     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (wrap) begin
        if (live[i] >= 4'd9) begin
          live_inc[i] = 4'd0;
        end else begin
          live_inc[i] = live[i] + 4'd1;
          wrap        = 1'b0;
        end
      end
    end
  end

  // Live count, lap hold register, overflow pulse and display register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= '0;
      hold <= '0;
      disp <= '0;
      ovf  <= 1'b0;
    end else begin
      ovf <= tick && wrap;
      if (clear_cnt) live <= '0;
      else if (tick) live <= live_inc;
      if (hold_load) hold <= live;
      disp <= (state == LAP) ? hold : live;
    end
  end

  assign digit1 = disp[3];
  assign digit2 = disp[2];
  assign digit3 = disp[1];
  assign digit4 = disp[0];

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed testbench for stopwatch_core with TICK_DIV=4, DEBOUNCE=3.
// Inputs are driven and outputs sampled on the falling clock edge. After a
// start press, m counts falling-edge samples from the first sample showing
// ptflag high; with no pauses the display then shows floor((m-1)/4)
// hundredths.
module tb_stopwatch_core;

  logic        clk;
  logic        rst_n;
  logic        btn_ss;
  logic        btn_lr;
  logic [3:0]  digit1, digit2, digit3, digit4;
  logic        ptflag;
  logic        ovf;
  logic [15:0] digits;

  int checks = 0;
  int passes = 0;
  int m = 0;

  stopwatch_core #(.TICK_DIV(4), .DEBOUNCE(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_ss (btn_ss),
    .btn_lr (btn_lr),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3),
    .digit4 (digit4),
    .ptflag (ptflag),
    .ovf    (ovf)
  );

  assign digits = {digit1, digit2, digit3, digit4};

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    m += n;
  endtask

  task automatic goto_m(input int t);
    while (m < t) step(1);
  endtask

  // Waits (bounded) for the first sample with ptflag high and sets m = 0.
  task automatic wait_pt(input string name);
    int n;
    n = 0;
    while (ptflag !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ptflag !== 1'b1) $display("FAIL %s: ptflag=%b after %0d cycles, required 1", name, ptflag, n);
    else passes++;
    m = 0;
  endtask

  task automatic test_reset();
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (digits !== 16'h0000) $display("FAIL reset_digits: got %h required 0000", digits);
    else passes++;
    checks++;
    if (ptflag !== 1'b0) $display("FAIL reset_ptflag: got %b required 0", ptflag);
    else passes++;
    checks++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b required 0", ovf);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_glitch();
    do_reset();
    btn_ss = 1'b1;
    step(2);
    btn_ss = 1'b0;
    step(20);
    checks++;
    if (ptflag !== 1'b0) $display("FAIL glitch_ptflag: got %b required 0", ptflag);
    else passes++;
    checks++;
    if (digits !== 16'h0000) $display("FAIL glitch_digits: got %h required 0000", digits);
    else passes++;
  endtask

  task automatic test_run();
    do_reset();
    btn_ss = 1'b1;
    wait_pt("run_entry");
    btn_ss = 1'b0;
    checks++;
    if (digits !== 16'h0000) $display("FAIL run_m0: got %h required 0000", digits);
    else passes++;
    goto_m(4);
    checks++;
    if (digits !== 16'h0000) $display("FAIL run_m4: got %h required 0000", digits);
    else passes++;
    goto_m(5);
    checks++;
    if (digits !== 16'h0001) $display("FAIL run_m5: got %h required 0001", digits);
    else passes++;
    goto_m(40);
    checks++;
    if (digits !== 16'h0009) $display("FAIL run_m40: got %h required 0009", digits);
    else passes++;
    goto_m(41);
    checks++;
    if (digits !== 16'h0010) $display("FAIL run_carry: got %h required 0010", digits);
    else passes++;
    checks++;
    if (ptflag !== 1'b1) $display("FAIL run_ptflag: got %b required 1", ptflag);
    else passes++;
  endtask

  task automatic test_lap();
    do_reset();
    btn_ss = 1'b1;
    wait_pt("lap_entry");
    btn_ss = 1'b0;
    goto_m(16);
    btn_lr = 1'b1;
    goto_m(22);
    btn_lr = 1'b0;
    goto_m(23);
    checks++;
    if (digits !== 16'h0005) $display("FAIL lap_freeze: got %h required 0005", digits);
    else passes++;
    goto_m(30);
    checks++;
    if (digits !== 16'h0005) $display("FAIL lap_hold: got %h required 0005", digits);
    else passes++;
    checks++;
    if (ptflag !== 1'b1) $display("FAIL lap_ptflag: got %b required 1", ptflag);
    else passes++;
    btn_lr = 1'b1;
    goto_m(36);
    btn_lr = 1'b0;
    goto_m(37);
    checks++;
    if (digits !== 16'h0009) $display("FAIL lap_release: got %h required 0009", digits);
    else passes++;
    goto_m(41);
    checks++;
    if (digits !== 16'h0010) $display("FAIL lap_live: got %h required 0010", digits);
    else passes++;
  endtask

  task automatic test_overflow();
    int ovf_cnt;
    int bad;
    ovf_cnt = 0;
    bad     = 0;
    do_reset();
    btn_ss = 1'b1;
    wait_pt("ovf_entry");
    btn_ss = 1'b0;
    for (int i = 1; i <= 40010; i++) begin
      @(negedge clk);
      m = i;
      if (ovf === 1'b1) ovf_cnt++;
      if (digit1 > 4'd9 || digit2 > 4'd9 || digit3 > 4'd9 || digit4 > 4'd9) bad++;
      if (m == 4001) begin
        checks++;
        if (digits !== 16'h1000) $display("FAIL ovf_ten_sec: got %h required 1000", digits);
        else passes++;
      end
      if (m == 40000) begin
        checks++;
        if (digits !== 16'h9999) $display("FAIL ovf_full: got %h required 9999", digits);
        else passes++;
        checks++;
        if (ovf !== 1'b1) $display("FAIL ovf_pulse: got %b required 1", ovf);
        else passes++;
      end
      if (m == 40001) begin
        checks++;
        if (digits !== 16'h0000) $display("FAIL ovf_wrap: got %h required 0000", digits);
        else passes++;
        checks++;
        if (ovf !== 1'b0) $display("FAIL ovf_end: got %b required 0", ovf);
        else passes++;
        checks++;
        if (ptflag !== 1'b1) $display("FAIL ovf_ptflag: got %b required 1", ptflag);
        else passes++;
      end
    end
    checks++;
    if (ovf_cnt != 1) $display("FAIL ovf_count: got %0d pulse cycles required 1", ovf_cnt);
    else passes++;
    checks++;
    if (bad != 0) $display("FAIL digit_range: got %0d samples above 9 required 0", bad);
    else passes++;
  endtask

  task automatic test_both_buttons();
    do_reset();
    btn_ss = 1'b1;
    wait_pt("both_entry");
    btn_ss = 1'b0;
    goto_m(43);
    btn_ss = 1'b1;
    goto_m(49);
    btn_ss = 1'b0;
    goto_m(60);
    checks++;
    if (digits !== 16'h0012) $display("FAIL stop_digits: got %h required 0012", digits);
    else passes++;
    checks++;
    if (ptflag !== 1'b0) $display("FAIL stop_ptflag: got %b required 0", ptflag);
    else passes++;
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    goto_m(66);
    checks++;
    if (ptflag !== 1'b1) $display("FAIL both_ptflag: got %b required 1", ptflag);
    else passes++;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    goto_m(69);
    checks++;
    if (digits !== 16'h0012) $display("FAIL both_resume_hold: got %h required 0012", digits);
    else passes++;
    goto_m(70);
    checks++;
    if (digits !== 16'h0013) $display("FAIL both_resume_tick: got %h required 0013", digits);
    else passes++;
    goto_m(74);
    checks++;
    if (digits !== 16'h0014) $display("FAIL both_running: got %h required 0014", digits);
    else passes++;
    btn_ss = 1'b1;
    goto_m(80);
    btn_ss = 1'b0;
    checks++;
    if (ptflag !== 1'b0) $display("FAIL stop2_ptflag: got %b required 0", ptflag);
    else passes++;
    goto_m(90);
    btn_lr = 1'b1;
    goto_m(96);
    btn_lr = 1'b0;
    goto_m(97);
    checks++;
    if (digits !== 16'h0000) $display("FAIL idle_digits: got %h required 0000", digits);
    else passes++;
    checks++;
    if (ptflag !== 1'b0) $display("FAIL idle_ptflag: got %b required 0", ptflag);
    else passes++;
    goto_m(100);
    btn_ss = 1'b1;
    goto_m(106);
    btn_ss = 1'b0;
    checks++;
    if (ptflag !== 1'b1) $display("FAIL restart_ptflag: got %b required 1", ptflag);
    else passes++;
    goto_m(110);
    checks++;
    if (digits !== 16'h0000) $display("FAIL restart_pre_clear: got %h required 0000", digits);
    else passes++;
    goto_m(111);
    checks++;
    if (digits !== 16'h0001) $display("FAIL restart_first_tick: got %h required 0001", digits);
    else passes++;
  endtask

  task automatic test_async_reset();
    do_reset();
    btn_ss = 1'b1;
    wait_pt("async_entry");
    btn_ss = 1'b0;
    goto_m(122);
    checks++;
    if (digits !== 16'h0030) $display("FAIL async_pre: got %h required 0030", digits);
    else passes++;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (digits !== 16'h0000) $display("FAIL async_digits: got %h required 0000", digits);
    else passes++;
    checks++;
    if (ptflag !== 1'b0) $display("FAIL async_ptflag: got %b required 0", ptflag);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (ptflag !== 1'b0 || digits !== 16'h0000)
      $display("FAIL async_idle: got ptflag=%b digits=%h required 0/0000", ptflag, digits);
    else passes++;
  endtask

  task automatic test_held_through_reset();
    btn_lr = 1'b0;
    btn_ss = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_pt("held_entry");
    repeat (30) @(negedge clk);
    checks++;
    if (ptflag !== 1'b1) $display("FAIL held_single_event: got ptflag=%b required 1", ptflag);
    else passes++;
    btn_ss = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (ptflag !== 1'b1) $display("FAIL held_release: got ptflag=%b required 1", ptflag);
    else passes++;
  endtask

  initial begin
    rst_n  = 1'b0;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    test_reset();
    test_glitch();
    test_run();
    test_lap();
    test_both_buttons();
    test_async_reset();
    test_held_through_reset();
    test_overflow();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
